spi_sample_rx_fifo: RTL

//  Upstream audio ingest stage: receives 16-bit PCM samples over SPI mode 0 (MSB first).

---
 rtl/audio_pkg.sv | 12 +
 rtl/spi_sample_rx_fifo_if.sv | 27 ++
 rtl/sample_fifo.sv | 48 ++++
 rtl/spi_sample_rx_fifo.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared audio types for the SPI sample ingest path: sample width, sample type and
// the receiver FSM state encoding.
package audio_pkg;
  localparam int SAMPLE_W = 16;

  typedef logic [SAMPLE_W-1:0] sample_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } rx_state_t;
endpackage

// File: rtl/spi_sample_rx_fifo_if.sv
// DSP-side sample interface: pop request, presented sample and status flags.
// Handshake: sample_req is a 1-cycle request; sample_valid pulses exactly one cycle later
// only when a sample was available, otherwise underrun is raised instead.
interface spi_sample_rx_fifo_if #(
  parameter int LEVEL_W = 4
);
  import audio_pkg::*;

  logic               sample_req;
  logic               clr_status;
  sample_t            sample_out;
  logic               sample_valid;
  logic [LEVEL_W-1:0] fifo_level;
  logic               overrun;
  logic               underrun;
  logic               frame_error;

  modport master (
    output sample_req, clr_status,
    input  sample_out, sample_valid, fifo_level, overrun, underrun, frame_error
  );

  modport slave (
    input  sample_req, clr_status,
    output sample_out, sample_valid, fifo_level, overrun, underrun, frame_error
  );
endinterface

// File: rtl/sample_fifo.sv
// Synchronous sample FIFO with wrap-bit pointers; a push into a full FIFO is accepted
// only when a pop retires the head in the same cycle.
module sample_fifo
  import audio_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        input_clk,
  input  logic                        reset,
  input  logic                        push,
  input  sample_t                     push_data,
  input  logic                        pop,
  output sample_t                     pop_data,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        full,
  output logic                        empty
);
  localparam int AW = $clog2(FIFO_DEPTH);

  sample_t       mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          wr_en;
  logic          rd_en;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level    = wr_ptr - rd_ptr;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  // Reading an empty FIFO never sees the word being written in the same cycle.
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);

  always_ff @(posedge input_clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge input_clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= push_data;
  end
endmodule

// File: rtl/spi_sample_rx_fifo.sv
// SPI mode-0 PCM sample receiver: pin synchronisers, word assembly FSM, sample FIFO and
// DSP-side output register with sticky fault flags. Optional macro: SPI_RX_HOLD_LAST_EN.
module spi_sample_rx_fifo
  import audio_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 input_clk,
  input  logic                 reset,
  input  logic                 spi_sclk,
  input  logic                 spi_cs_n,
  input  logic                 spi_mosi,
  spi_sample_rx_fifo_if.slave  rx,
  output rx_state_t            state_dbg
);
  localparam int CNT_W = $clog2(SAMPLE_W);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SAMPLE_W - 1);

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_d;
  logic                   cs_d;
  logic                   sync_sclk;
  logic                   sync_cs_n;
  logic                   sync_mosi;
  logic                   sclk_rise;
  logic                   cs_fall;
  logic                   cs_rise;

  rx_state_t              state;
  logic [CNT_W-1:0]       bit_cnt;
  sample_t                shift_reg;
  logic                   push_strobe;
  sample_t                push_word;
  logic                   frame_fault;

  sample_t                pop_data;
  logic [LVL_W-1:0]       level;
  logic                   full;
  logic                   empty;

  sample_t                sample_out_q;
  logic                   sample_valid_q;
  logic                   overrun_q;
  logic                   underrun_q;
  logic                   frame_error_q;

  // Idle pin levels on reset so no false SCLK or CS edge fires on release.
  always_ff @(posedge input_clk or negedge reset) begin
    if (!reset) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
      cs_d      <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign sync_sclk = sclk_sync[SYNC_STAGES-1];
  assign sync_cs_n = cs_sync[SYNC_STAGES-1];
  assign sync_mosi = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sync_sclk & ~sclk_d;
  assign cs_fall   = ~sync_cs_n & cs_d;
  assign cs_rise   = sync_cs_n & ~cs_d;

  always_ff @(posedge input_clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      push_strobe <= 1'b0;
      push_word   <= '0;
      frame_fault <= 1'b0;
    end else begin
      push_strobe <= 1'b0;
      frame_fault <= 1'b0;
      case (state)
        IDLE: begin
          if (cs_fall) begin
            bit_cnt <= '0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          // CS release outranks a coincident SCLK edge: the frame is over.
          if (cs_rise) begin
            state <= IDLE;
            if (bit_cnt != '0) frame_fault <= 1'b1;
            bit_cnt <= '0;
          end else if (sclk_rise) begin
            shift_reg <= {shift_reg[SAMPLE_W-2:0], sync_mosi};
            if (bit_cnt == LAST_BIT) begin
              bit_cnt     <= '0;
              push_strobe <= 1'b1;
              push_word   <= {shift_reg[SAMPLE_W-2:0], sync_mosi};
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  sample_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .input_clk (input_clk),
    .reset     (reset),
    .push      (push_strobe),
    .push_data (push_word),
    .pop       (rx.sample_req),
    .pop_data  (pop_data),
    .level     (level),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge input_clk or negedge reset) begin
    if (!reset) begin
      sample_out_q   <= '0;
      sample_valid_q <= 1'b0;
    end else begin
      sample_valid_q <= 1'b0;
      if (rx.sample_req) begin
        if (!empty) begin
          sample_out_q   <= pop_data;
          sample_valid_q <= 1'b1;
        end else begin
`ifdef SPI_RX_HOLD_LAST_EN
          sample_out_q <= sample_out_q;
`else
          sample_out_q <= '0;
`endif
        end
      end
    end
  end

  // A fault in the same cycle as clr_status keeps its flag set.
  always_ff @(posedge input_clk or negedge reset) begin
    if (!reset) begin
      overrun_q     <= 1'b0;
      underrun_q    <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      if (push_strobe && full && !rx.sample_req) overrun_q <= 1'b1;
      else if (rx.clr_status)                    overrun_q <= 1'b0;

      if (rx.sample_req && empty) underrun_q <= 1'b1;
      else if (rx.clr_status)     underrun_q <= 1'b0;

      if (frame_fault)            frame_error_q <= 1'b1;
      else if (rx.clr_status)     frame_error_q <= 1'b0;
    end
  end

  assign rx.sample_out   = sample_out_q;
  assign rx.sample_valid = sample_valid_q;
  assign rx.fifo_level   = level;
  assign rx.overrun      = overrun_q;
  assign rx.underrun     = underrun_q;
  assign rx.frame_error  = frame_error_q;
  assign state_dbg       = state;
endmodule
